// File: rtl/bus_controller.sv
// bus_controller: decodes CPU bus requests to RAM / MMIO / unmapped, steers byte lanes
// and returns exactly one registered response pulse per accepted request.
module bus_controller #(
    parameter int          RAM_ADDR_W   = 14,
    parameter logic [15:0] MMIO_BASE_HI = 16'hFFFF,
    parameter int          MMIO_TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [31:0]           i_bus_address,
    input  logic [31:0]           i_bus_data,
    input  logic                  i_bus_DV,
    input  logic [2:0]            i_bhw,
    input  logic                  i_write_notread,
    output logic [31:0]           o_bus_data,
    output logic                  o_bus_DV,
    output logic                  o_bus_err,
    output logic                  o_busy,
    output logic                  o_ram_en,
    output logic [3:0]            o_ram_we,
    output logic [RAM_ADDR_W-1:0] o_ram_addr,
    output logic [31:0]           o_ram_wdata,
    input  logic [31:0]           i_ram_rdata,
    output logic                  o_mmio_req,
    output logic                  o_mmio_we,
    output logic [15:0]           o_mmio_addr,
    output logic [31:0]           o_mmio_wdata,
    input  logic                  i_mmio_ack,
    input  logic [31:0]           i_mmio_rdata
);
    localparam int CW = $clog2(MMIO_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RAM_ACC, RAM_RD, MMIO_WAIT, RESP} state_t;

    state_t          state_q;
    logic [1:0]      off_q;
    logic [2:0]      bhw_q;
    logic            wr_q;
    logic [CW-1:0]   cnt_q;

    logic            is_ram_d, is_mmio_d, bad_size_d, misaligned_d, err_d;
    logic [3:0]      we_d;
    logic [31:0]     wdata_d, shifted_d, load_d;

    assign is_ram_d     = i_bus_address[31:RAM_ADDR_W+2] == '0;
    assign is_mmio_d    = i_bus_address[31:16] == MMIO_BASE_HI;
    assign bad_size_d   = (i_bhw[1:0] == 2'b11) | (i_bhw[2:1] == 2'b11);
    assign misaligned_d = (i_bhw[1:0] == 2'b01 & i_bus_address[0]) |
                          (i_bhw[1:0] == 2'b10 & |i_bus_address[1:0]);
    assign err_d        = bad_size_d | misaligned_d | ~(is_ram_d | is_mmio_d) |
                          (is_mmio_d & i_bhw != 3'b010);
    assign we_d         = i_bhw[1] ? 4'hF : i_bhw[0] ? (i_bus_address[1] ? 4'hC : 4'h3)
                                                     : 4'b0001 << i_bus_address[1:0];
    assign wdata_d      = i_bhw[1] ? i_bus_data : i_bhw[0] ? {2{i_bus_data[15:0]}}
                                                           : {4{i_bus_data[7:0]}};
    // Word loads are aligned, so the byte-offset shift is zero for them
    assign shifted_d    = i_ram_rdata >> (bhw_q[0] ? {off_q[1], 4'b0} : {off_q, 3'b0});
    assign load_d       = bhw_q[1] ? shifted_d :
                          bhw_q[0] ? {{16{shifted_d[15] & ~bhw_q[2]}}, shifted_d[15:0]}
                                   : {{24{shifted_d[7] & ~bhw_q[2]}}, shifted_d[7:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            off_q        <= '0;
            bhw_q        <= '0;
            wr_q         <= 1'b0;
            cnt_q        <= '0;
            o_bus_data   <= '0;
            o_bus_DV     <= 1'b0;
            o_bus_err    <= 1'b0;
            o_busy       <= 1'b0;
            o_ram_en     <= 1'b0;
            o_ram_we     <= '0;
            o_ram_addr   <= '0;
            o_ram_wdata  <= '0;
            o_mmio_req   <= 1'b0;
            o_mmio_we    <= 1'b0;
            o_mmio_addr  <= '0;
            o_mmio_wdata <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_bus_DV) begin
                    off_q  <= i_bus_address[1:0];
                    bhw_q  <= i_bhw;
                    wr_q   <= i_write_notread;
                    o_busy <= 1'b1;
                    if (err_d) begin
                        state_q    <= RESP;
                        o_bus_DV   <= 1'b1;
                        o_bus_err  <= 1'b1;
                        o_bus_data <= '0;
                    end else if (is_mmio_d) begin
                        state_q      <= MMIO_WAIT;
                        cnt_q        <= '0;
                        o_mmio_req   <= 1'b1;
                        o_mmio_we    <= i_write_notread;
                        o_mmio_addr  <= i_bus_address[15:0];
                        o_mmio_wdata <= i_bus_data;
                    end else begin
                        state_q     <= RAM_ACC;
                        o_ram_en    <= 1'b1;
                        o_ram_addr  <= i_bus_address[RAM_ADDR_W+1:2];
                        o_ram_we    <= i_write_notread ? we_d : 4'h0;
                        o_ram_wdata <= wdata_d;
                    end
                end
                RAM_ACC: begin
                    state_q  <= RAM_RD;
                    o_ram_en <= 1'b0;
                    o_ram_we <= '0;
                end
                RAM_RD: begin
                    state_q    <= RESP;
                    o_bus_DV   <= 1'b1;
                    o_bus_err  <= 1'b0;
                    o_bus_data <= wr_q ? 32'h0 : load_d;
                end
                MMIO_WAIT: if (i_mmio_ack) begin
                    state_q    <= RESP;
                    o_mmio_req <= 1'b0;
                    o_bus_DV   <= 1'b1;
                    o_bus_err  <= 1'b0;
                    o_bus_data <= wr_q ? 32'h0 : i_mmio_rdata;
                end else if (cnt_q == CW'(MMIO_TIMEOUT - 1)) begin
                    state_q    <= RESP;
                    o_mmio_req <= 1'b0;
                    o_bus_DV   <= 1'b1;
                    o_bus_err  <= 1'b1;
                    o_bus_data <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                RESP: begin
                    state_q   <= IDLE;
                    o_bus_DV  <= 1'b0;
                    o_bus_err <= 1'b0;
                    o_busy    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_controller.sv
// tb_bus_controller: random + directed stimulus against a byte-level memory model;
// responses and RAM strobes are checked by an independent scoreboard monitor.
module tb_bus_controller;
    logic        i_clk = 0, i_rst = 1;
    logic [31:0] i_bus_address = 0, i_bus_data = 0;
    logic        i_bus_DV = 0, i_write_notread = 0;
    logic [2:0]  i_bhw = 0;
    logic [31:0] o_bus_data;
    logic        o_bus_DV, o_bus_err, o_busy, o_ram_en;
    logic [3:0]  o_ram_we;
    logic [13:0] o_ram_addr;
    logic [31:0] o_ram_wdata, i_ram_rdata = 0;
    logic        o_mmio_req, o_mmio_we, i_mmio_ack = 0;
    logic [15:0] o_mmio_addr;
    logic [31:0] o_mmio_wdata, i_mmio_rdata = 0;

    bus_controller dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_bus_address(i_bus_address), .i_bus_data(i_bus_data),
        .i_bus_DV(i_bus_DV), .i_bhw(i_bhw), .i_write_notread(i_write_notread),
        .o_bus_data(o_bus_data), .o_bus_DV(o_bus_DV), .o_bus_err(o_bus_err), .o_busy(o_busy),
        .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata), .o_mmio_req(o_mmio_req),
        .o_mmio_we(o_mmio_we), .o_mmio_addr(o_mmio_addr), .o_mmio_wdata(o_mmio_wdata),
        .i_mmio_ack(i_mmio_ack), .i_mmio_rdata(i_mmio_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [31:0] data; logic err; int cyc; } resp_t;
    typedef struct { logic [13:0] addr; logic [3:0] we; logic [31:0] wdata; int cyc; } ramop_t;

    resp_t       sb[$];
    ramop_t      ram_q[$];
    int          n_checks = 0, n_fail = 0, cyc = 0;
    logic [31:0] ram [0:16383];
    logic [7:0]  ref_mem [0:65535];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Synchronous RAM seen by the DUT
    always @(posedge i_clk) if (o_ram_en) begin
        for (int i = 0; i < 4; i++)
            if (o_ram_we[i]) ram[o_ram_addr][8*i +: 8] <= o_ram_wdata[8*i +: 8];
        i_ram_rdata <= ram[o_ram_addr];
    end

    // Monitor: every response and RAM strobe must match the next expected entry
    always @(negedge i_clk) begin
        resp_t  e;
        ramop_t r;
        if (o_bus_DV) begin
            if (sb.size() == 0) chk("unexpected_dv", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("resp_data", o_bus_data, e.data);
                chk("resp_err", {31'b0, o_bus_err}, {31'b0, e.err});
                chk("resp_cycle", cyc, e.cyc);
                chk("busy_at_dv", {31'b0, o_busy}, 32'd1);
            end
        end
        if (o_ram_en) begin
            if (ram_q.size() == 0) chk("unexpected_ram_en", 32'd1, 32'd0);
            else begin
                r = ram_q.pop_front();
                chk("ram_addr", {18'b0, o_ram_addr}, {18'b0, r.addr});
                chk("ram_we", {28'b0, o_ram_we}, {28'b0, r.we});
                if (r.we != 0) chk("ram_wdata", o_ram_wdata, r.wdata);
                chk("ram_cycle", cyc, r.cyc);
            end
        end
    end

    // Issue one request at a negedge, predict its outcome, service MMIO, wait for idle
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] b,
                         input logic w, input int ack_dly, input logic [31:0] mrd, input int spur);
        int          sz, m, reqc, n, exp_reqc;
        logic        is_ram, is_mm, err, acked;
        logic [31:0] v;
        m      = cyc;
        sz     = (b[1:0] == 2'b00) ? 1 : (b[1:0] == 2'b01) ? 2 : 4;
        is_ram = a < 32'h0001_0000;
        is_mm  = a[31:16] == 16'hFFFF;
        err    = (b == 3'd3) || (b >= 3'd6) || (a % sz != 0) || !(is_ram || is_mm) ||
                 (is_mm && b != 3'b010);
        acked  = ack_dly >= 1 && ack_dly <= 255;
        exp_reqc = acked ? ack_dly : 255;
        if (err) sb.push_back('{32'h0, 1'b1, m + 1});
        else if (is_ram) begin
            v = 0;
            if (w) for (int i = 0; i < sz; i++) ref_mem[a + i] = d[8*i +: 8];
            else begin
                for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
                if (!b[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 1);
            end
            ram_q.push_back('{a[15:2], w ? 4'(((1 << sz) - 1) << a[1:0]) : 4'h0,
                              sz == 1 ? {24'b0, d[7:0]} * 32'h0101_0101 :
                              sz == 2 ? {16'b0, d[15:0]} * 32'h0001_0001 : d, m + 1});
            sb.push_back('{v, 1'b0, m + 3});
        end else
            sb.push_back('{(acked && !w) ? mrd : 32'h0, !acked, acked ? m + ack_dly + 1 : m + 256});
        i_bus_address = a; i_bus_data = d; i_bhw = b; i_write_notread = w; i_bus_DV = 1;
        @(negedge i_clk);
        i_bus_DV = 0;
        if (!err && is_mm) begin
            reqc = 0;
            while (o_mmio_req && reqc < 300) begin
                reqc++;
                if (reqc == 1) begin
                    chk("mmio_addr", {16'b0, o_mmio_addr}, {16'b0, a[15:0]});
                    chk("mmio_we", {31'b0, o_mmio_we}, {31'b0, w});
                    if (w) chk("mmio_wdata", o_mmio_wdata, d);
                end
                if (reqc == ack_dly) begin i_mmio_ack = 1; i_mmio_rdata = mrd; end
                if (reqc == spur) i_bus_DV = 1;
                @(negedge i_clk);
                i_mmio_ack = 0; i_bus_DV = 0;
            end
            chk("mmio_req_cycles", reqc, exp_reqc);
        end
        n = 0;
        while (o_busy && n < 400) begin n++; @(negedge i_clk); end
        if (n >= 400) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int          k;
        logic [31:0] a;
        logic [2:0]  b;
        for (int i = 0; i < 16384; i++) ram[i] = 0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 0;
        repeat (3) @(negedge i_clk);
        chk("rst_dv", {31'b0, o_bus_DV}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_ram_en", {31'b0, o_ram_en}, 32'd0);
        chk("rst_ram_we", {28'b0, o_ram_we}, 32'd0);
        chk("rst_mmio_req", {31'b0, o_mmio_req}, 32'd0);
        chk("rst_bus_data", o_bus_data, 32'd0);
        i_rst = 0;
        issue(32'h100, 32'h1234_5678, 3'b010, 1, 0, 0, -1);
        issue(32'h100, 32'h0, 3'b010, 0, 0, 0, -1);
        issue(32'h103, 32'h0000_00AB, 3'b000, 1, 0, 0, -1);
        issue(32'h103, 32'h0, 3'b000, 0, 0, 0, -1);
        issue(32'h103, 32'h0, 3'b100, 0, 0, 0, -1);
        issue(32'h100, 32'h8001_7FFF, 3'b010, 1, 0, 0, -1);
        issue(32'h102, 32'h0, 3'b001, 0, 0, 0, -1);
        issue(32'h101, 32'h0, 3'b001, 0, 0, 0, -1);
        issue(32'hFFFF_0010, 32'h0, 3'b010, 0, 5, 32'hCAFE_F00D, -1);
        issue(32'hFFFF_0020, 32'h55, 3'b000, 1, 0, 0, -1);
        issue(32'hFFFF_0030, 32'h0, 3'b010, 0, 0, 32'h0, 10);
        // Reset during MMIO_WAIT aborts the request without a response
        i_bus_address = 32'hFFFF_0040; i_bhw = 3'b010; i_write_notread = 0; i_bus_DV = 1;
        @(negedge i_clk);
        i_bus_DV = 0;
        chk("mmio_req_before_rst", {31'b0, o_mmio_req}, 32'd1);
        @(negedge i_clk);
        i_rst = 1;
        @(negedge i_clk);
        chk("mmio_req_after_rst", {31'b0, o_mmio_req}, 32'd0);
        chk("busy_after_rst", {31'b0, o_busy}, 32'd0);
        i_rst = 0;
        issue(32'h104, 32'hDEAD_BEEF, 3'b010, 1, 0, 0, -1);
        issue(32'h104, 32'h0, 3'b101, 0, 0, 0, -1);
        for (int t = 0; t < 200; t++) begin
            k = $urandom_range(0, 9);
            a = (k < 7) ? 32'($urandom_range(0, 4095)) :
                (k < 8) ? (32'h0001_0000 | ($urandom & 32'h7FFF_FFFF)) :
                          (32'hFFFF_0000 | ($urandom & 32'h0000_FFFF));
            b = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) :
                (a[31:16] == 16'hFFFF) ? 3'b010 : 3'($urandom_range(0, 2));
            if (b != 3'b010 && $urandom_range(0, 1) == 1 && b[1:0] != 2'b11) b[2] = 1'b1;
            if (b == 3'b010 || b == 3'b001 || b == 3'b101) a[0] = ($urandom_range(0, 7) == 0);
            if (b == 3'b010 && $urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            issue(a, $urandom, b, 1'($urandom_range(0, 1)), $urandom_range(1, 8), $urandom, -1);
        end
        repeat (3) @(negedge i_clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("ramq_empty", ram_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
